// File: rtl/serial_negate32_if.sv
// Handshake and data bundle for the bit-serial complement unit.
// The slave side is the complement unit. The master side is the operand
// producer together with the result consumer.
interface serial_negate32_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] data_in;
  logic             op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] data_out;
  logic             overflow;
  logic             zero;
  logic             busy;

  modport master (
    output in_valid, data_in, op, out_ready,
    input  in_ready, out_valid, data_out, overflow, zero, busy
  );

  modport slave (
    input  in_valid, data_in, op, out_ready,
    output in_ready, out_valid, data_out, overflow, zero, busy
  );
endinterface

// File: rtl/serial_negate32.sv
// Bit-serial complement unit: computes ~x (op=0) or ~x+1 (op=1).
// It handles one bit per clock, LSB first, using a single ripple-carry flop.
// Result is offered through a valid/ready handshake and held until taken.
module serial_negate32 #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic              clock,
  input  logic              reset_n,
  serial_negate32_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] sr;
  logic [WIDTH-1:0] res;
  logic [CNT_W-1:0] cnt;
  logic             carry;
  logic             ovf_pend;

  logic             in_ready_q;
  logic             out_valid_q;
  logic             busy_q;
  logic [WIDTH-1:0] data_out_q;
  logic             overflow_q;
  logic             zero_q;

  logic             bit_now;
  logic [WIDTH-1:0] res_next;

  // Next result bit and the result register as it looks after this shift.
  always_comb begin
    bit_now  = ~sr[0] ^ carry;
    res_next = {bit_now, res[WIDTH-1:1]};
  end

  // Control FSM with every handshake output and flag registered.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      sr          <= '0;
      res         <= '0;
      cnt         <= '0;
      carry       <= 1'b0;
      ovf_pend    <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      data_out_q  <= '0;
      overflow_q  <= 1'b0;
      zero_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            sr         <= bus.data_in;
            carry      <= bus.op;
            cnt        <= '0;
            ovf_pend   <= bus.op & bus.data_in[WIDTH-1] & ~(|bus.data_in[WIDTH-2:0]);
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            state      <= SHIFT;
          end
        end
        SHIFT: begin
          sr    <= sr >> 1;
          carry <= ~sr[0] & carry;
          res   <= res_next;
          cnt   <= cnt + 1'b1;
          if (cnt == CNT_W'(WIDTH - 1)) begin
            data_out_q  <= res_next;
            zero_q      <= (res_next == '0);
            overflow_q  <= ovf_pend;
            out_valid_q <= 1'b1;
            busy_q      <= 1'b0;
            state       <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
            zero_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            state       <= IDLE;
          end
        end
        default: begin
          state       <= IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy_q;
  assign bus.data_out  = data_out_q;
  assign bus.overflow  = overflow_q;
  assign bus.zero      = zero_q;

endmodule
